// File: rtl/prog_loader.sv
// Instruction-memory loader: assembles little-endian words from a byte stream,
// writes them from address 0 and releases the core only after a good XOR checksum.
module prog_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [7:0]        byte_i,
  input  logic              byte_valid_i,
  output logic              byte_ready_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              cpu_rst_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W:0]   words_o
);

  typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, CHK, DONE} state_t;

  state_t            state, state_n;
  logic [7:0]        len, len_n;
  logic [1:0]        lane, lane_n;
  logic [23:0]       word_lo, word_lo_n;
  logic [7:0]        acc, acc_n;
  logic              ready_n, we_n, cpu_rst_n, busy_n, done_n, err_n;
  logic [ADDR_W-1:0] addr_n;
  logic [31:0]       wdata_n;
  logic [ADDR_W:0]   words_n, words_inc;
  logic              fire;

  assign fire      = byte_valid_i & byte_ready_o;
  assign words_inc = words_o + 1'b1;

  // All outputs are registered: next values are computed here for the state being entered.
  always_comb begin
    state_n   = state;
    len_n     = len;
    lane_n    = lane;
    word_lo_n = word_lo;
    acc_n     = acc;
    ready_n   = byte_ready_o;
    we_n      = 1'b0;
    addr_n    = mem_addr_o;
    wdata_n   = mem_wdata_o;
    cpu_rst_n = cpu_rst_o;
    busy_n    = busy_o;
    done_n    = done_o;
    err_n     = err_o;
    words_n   = words_o;
    case (state)
      IDLE, DONE: begin
        if (start_i) begin
          state_n   = LEN;
          ready_n   = 1'b1;
          busy_n    = 1'b1;
          cpu_rst_n = 1'b1;
          done_n    = 1'b0;
          err_n     = 1'b0;
          words_n   = '0;
          lane_n    = '0;
          acc_n     = '0;
        end
      end
      LEN: begin
        if (fire) begin
          len_n   = byte_i;
          state_n = (byte_i == 8'd0) ? CHK : DATA;
        end
      end
      DATA: begin
        if (fire) begin
          acc_n = acc ^ byte_i;
          case (lane)
            2'd0: word_lo_n[7:0]   = byte_i;
            2'd1: word_lo_n[15:8]  = byte_i;
            2'd2: word_lo_n[23:16] = byte_i;
            default: begin
              state_n = WRITE;
              ready_n = 1'b0;
              we_n    = 1'b1;
              addr_n  = words_o[ADDR_W-1:0];
              wdata_n = {byte_i, word_lo};
            end
          endcase
          lane_n = lane + 2'd1;
        end
      end
      WRITE: begin
        words_n = words_inc;
        ready_n = 1'b1;
        state_n = (words_inc == {{(ADDR_W-7){1'b0}}, len}) ? CHK : DATA;
      end
      CHK: begin
        if (fire) begin
          state_n   = DONE;
          ready_n   = 1'b0;
          busy_n    = 1'b0;
          done_n    = 1'b1;
          err_n     = (byte_i != acc);
          cpu_rst_n = (byte_i != acc);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state        <= IDLE;
      len          <= '0;
      lane         <= '0;
      word_lo      <= '0;
      acc          <= '0;
      byte_ready_o <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
      cpu_rst_o    <= 1'b1;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
      words_o      <= '0;
    end else begin
      state        <= state_n;
      len          <= len_n;
      lane         <= lane_n;
      word_lo      <= word_lo_n;
      acc          <= acc_n;
      byte_ready_o <= ready_n;
      mem_we_o     <= we_n;
      mem_addr_o   <= addr_n;
      mem_wdata_o  <= wdata_n;
      cpu_rst_o    <= cpu_rst_n;
      busy_o       <= busy_n;
      done_o       <= done_n;
      err_o        <= err_n;
      words_o      <= words_n;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected memory writes are queued by the
// stimulus and popped by a monitor on each mem_we_o pulse.
module tb_prog_loader;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst_i = 1'b0;
  logic              start_i = 1'b0;
  logic [7:0]        byte_i = '0;
  logic              byte_valid_i = 1'b0;
  logic              byte_ready_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic              cpu_rst_o;
  logic              busy_o;
  logic              done_o;
  logic              err_o;
  logic [ADDR_W:0]   words_o;

  int unsigned tests = 0;
  int unsigned fails = 0;
  logic [39:0] exp_q[$];

  logic [7:0]  stream [8] = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
  logic [31:0] words  [2] = '{32'h12345678, 32'hDEADBEEF};

  prog_loader #(.ADDR_W(ADDR_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .byte_i(byte_i),
    .byte_valid_i(byte_valid_i), .byte_ready_o(byte_ready_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .cpu_rst_o(cpu_rst_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .words_o(words_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (mem_we_o === 1'b1) begin
      logic [39:0] e;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none", mem_addr_o, mem_wdata_o);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", 32'(mem_addr_o), 32'(e[39:32]));
        check("write_data", mem_wdata_o, e[31:0]);
        check("ready_in_write", 32'(byte_ready_o), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  // Present a byte and wait for its transfer edge; hold keeps valid asserted afterwards.
  task automatic send(input logic [7:0] b, input bit hold);
    int unsigned cnt = 0;
    byte_i = b;
    byte_valid_i = 1'b1;
    while (byte_ready_o !== 1'b1 && cnt < 20) begin
      tick();
      cnt++;
    end
    if (cnt >= 20) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: got ready=%0b expected 1 within 20 cycles", byte_ready_o);
    end
    tick();
    if (!hold) byte_valid_i = 1'b0;
  endtask

  task automatic full_load(input logic [7:0] ck, input bit hold);
    exp_q.push_back({8'h00, words[0]});
    exp_q.push_back({8'h01, words[1]});
    pulse_start();
    send(8'd2, hold);
    for (int i = 0; i < 8; i++) send(stream[i], hold);
    send(ck, 1'b0);
  endtask

  task automatic check_end(input string tag, input logic err, input logic cpu_rst, input int unsigned w);
    check({tag, "_done"}, 32'(done_o), 32'd1);
    check({tag, "_err"}, 32'(err_o), 32'(err));
    check({tag, "_cpu_rst"}, 32'(cpu_rst_o), 32'(cpu_rst));
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
    check({tag, "_words"}, 32'(words_o), w);
    check({tag, "_pending_writes"}, exp_q.size(), 32'd0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ready"}, 32'(byte_ready_o), 32'd0);
    check({tag, "_we"}, 32'(mem_we_o), 32'd0);
    check({tag, "_addr"}, 32'(mem_addr_o), 32'd0);
    check({tag, "_wdata"}, mem_wdata_o, 32'd0);
    check({tag, "_cpu_rst"}, 32'(cpu_rst_o), 32'd1);
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
    check({tag, "_done"}, 32'(done_o), 32'd0);
    check({tag, "_err"}, 32'(err_o), 32'd0);
    check({tag, "_words"}, 32'(words_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b1;
    check_reset("por");

    // 1: happy path
    full_load(8'h2A, 1'b0);
    check_end("happy", 1'b0, 1'b0, 2);

    // 2: bad checksum
    full_load(8'h2B, 1'b0);
    check_end("badchk", 1'b1, 1'b1, 2);

    // 3: empty load
    pulse_start();
    send(8'd0, 1'b0);
    send(8'h00, 1'b0);
    check_end("empty", 1'b0, 1'b0, 0);

    // 4: continuous valid
    full_load(8'h2A, 1'b1);
    check_end("backpressure", 1'b0, 1'b0, 2);

    // 5: reset after 5 data bytes (first word already written)
    exp_q.push_back({8'h00, words[0]});
    pulse_start();
    send(8'd2, 1'b0);
    for (int i = 0; i < 5; i++) send(stream[i], 1'b0);
    rst_i = 1'b0;
    tick();
    rst_i = 1'b1;
    check_reset("midrst");
    full_load(8'h2A, 1'b0);
    check_end("after_rst", 1'b0, 1'b0, 2);

    // 6a: start during DATA ignored
    exp_q.push_back({8'h00, words[0]});
    exp_q.push_back({8'h01, words[1]});
    pulse_start();
    send(8'd2, 1'b0);
    send(stream[0], 1'b0);
    send(stream[1], 1'b0);
    pulse_start();
    check("start_in_data_busy", 32'(busy_o), 32'd1);
    for (int i = 2; i < 8; i++) send(stream[i], 1'b0);
    send(8'h2A, 1'b0);
    check_end("start_in_data", 1'b0, 1'b0, 2);

    // 6b: restart from DONE after success
    pulse_start();
    check("restart_cpu_rst", 32'(cpu_rst_o), 32'd1);
    check("restart_done", 32'(done_o), 32'd0);
    check("restart_busy", 32'(busy_o), 32'd1);
    check("restart_words", 32'(words_o), 32'd0);
    exp_q.push_back({8'h00, words[0]});
    exp_q.push_back({8'h01, words[1]});
    send(8'd2, 1'b0);
    for (int i = 0; i < 8; i++) send(stream[i], 1'b0);
    send(8'h2A, 1'b0);
    check_end("restart", 1'b0, 1'b0, 2);

    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the instruction memory: receives a byte stream (e.g. from a UART receiver) and assembles 32-bit instruction words little-endian.
- Writes each word into instruction memory at consecutive addresses from 0.
- Holds the processor core in reset while loading and releases it only after a verified checksum.
- Sits between the host byte interface and the instruction memory write port, beside the core's PC/fetch path.

Parameters:
- ADDR_W, 8, instruction memory word-address width; legal range 8..16.

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-low reset.
- start_i  in  1  one-cycle pulse that begins a load session.
- byte_i  in  8  incoming data byte.
- byte_valid_i  in  1  byte_i is valid.
- byte_ready_o  out  1  loader accepts byte this cycle.
- mem_we_o  out  1  instruction memory write enable, one-cycle pulse per word.
- mem_addr_o  out  ADDR_W  word address for write.
- mem_wdata_o  out  32  instruction word to write.
- cpu_rst_o  out  1  active-high hold-in-reset to the core.
- busy_o  out  1  session in progress.
- done_o  out  1  last session finished, level.
- err_o  out  1  last session checksum mismatch, level.
- words_o  out  ADDR_W+1  number of words written in current/last session.

Behaviour:
- Reset (rst_i=0 at a clock edge) puts outputs at these values:
  - byte_ready_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, busy_o=0, done_o=0, err_o=0, words_o=0.
  - cpu_rst_o=1, so the core stays held after power-up until a successful load.
- A byte transfers on any edge where byte_valid_i=1 and byte_ready_o=1. Outputs are registered.
- Reset mid-session aborts the session and restores reset values. Words already written are not rolled back.
- FSM states: IDLE, LEN, DATA, WRITE, CHK, DONE.
  - IDLE: byte_ready_o=0. On start_i: go to LEN, set busy_o=1, cpu_rst_o=1, done_o=0, err_o=0, words_o=0, clear word index, byte lane counter and XOR accumulator.
  - LEN: byte_ready_o=1. Accepted byte = word count N (0..255). If N=0, go to CHK; else go to DATA.
  - DATA: byte_ready_o=1. Accepted bytes fill lanes 0..3 of the word (byte k → bits 8k+7:8k). Each data byte is XORed into the accumulator. On acceptance of lane 3, go to WRITE.
  - WRITE: exactly one cycle, byte_ready_o=0.
    - mem_we_o=1, mem_addr_o=word index, mem_wdata_o=assembled word.
    - The index increments at the end of the cycle and words_o tracks it.
    - If the new index equals N, go to CHK; else go to DATA.
  - CHK: byte_ready_o=1. Accepted byte is compared with the XOR accumulator (XOR of all 4N data bytes; the length byte is excluded).
    - Match: go to DONE, done_o=1, err_o=0, cpu_rst_o=0.
    - Mismatch: go to DONE, done_o=1, err_o=1, cpu_rst_o stays 1.
    - In both cases busy_o=0.
  - DONE: byte_ready_o=0; outputs held. start_i starts a new session exactly as from IDLE, including reasserting cpu_rst_o.
- start_i in LEN/DATA/WRITE/CHK is ignored.
- A valid byte presented during WRITE/IDLE/DONE is not consumed; the source must hold it.
- mem_we_o is high only in WRITE. mem_addr_o/mem_wdata_o hold their last values otherwise.
- Word index wraps never: N ≤ 255 < 2^ADDR_W.

Test Plan:
1. Happy path. start; N=2; bytes 78 56 34 12 EF BE AD DE; chk 2A.
   - Writes: addr0=0x12345678, addr1=0xDEADBEEF, each with a single mem_we_o pulse.
   - End state: done_o=1, err_o=0, cpu_rst_o=0, words_o=2.
2. Bad checksum. Same stream as scenario 1 with chk 2B.
   - Both writes occur.
   - End state: done_o=1, err_o=1, cpu_rst_o=1, busy_o=0.
3. Empty load. start; N=0; chk 00.
   - No mem_we_o pulse.
   - End state: done_o=1, err_o=0, cpu_rst_o=0, words_o=0.
4. Backpressure. byte_valid_i held high continuously over scenario 1's stream.
   - byte_ready_o=0 for the WRITE cycle after each 4th data byte.
   - No byte is lost or duplicated; same memory contents as scenario 1.
5. Reset mid-session. rst_i=0 for 1 cycle after 5 data bytes.
   - All outputs at reset values next cycle.
   - A subsequent full scenario 1 load writes from addr 0.
6. start_i handling.
   - start_i during DATA: no effect.
   - start_i in DONE after success: cpu_rst_o=1, done_o=0, busy_o=1 next cycle, and a new load proceeds.
